cruise_ctrl_fsm: RTL and testbench

Parametrised cruise controller: the successor to the team's fixed 8-bit cruise block. It holds vehicle speed and cruise set-point in registers of configurable width and tracks them with an explicit OFF/ACTIVE/SUSPENDED state machine. Set-point memory survives brake and cancel. All arithmetic saturates, with no wrap-around, and simultaneous pedal/button inputs resolve by a fixed priority. It sits between the driver-input debouncers and the speed display/actuator logic.

---
 rtl/cruise_ctrl_fsm.sv | 122 ++++++++++++
 tb/tb_cruise_ctrl_fsm.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cruise_ctrl_fsm.sv
// cruise_ctrl_fsm: parametrised cruise controller.
// Keeps vehicle speed and a remembered set-point, and tracks the cruise mode
// with an OFF / ACTIVE / SUSPENDED state machine. Every arithmetic path is
// evaluated one bit wider than the registers so it can clamp instead of wrap.
module cruise_ctrl_fsm #(
  parameter int unsigned W          = 8,
  parameter int unsigned MIN_SET    = 45,
  parameter int unsigned MAX_SPEED  = 2**W-1,
  parameter int unsigned THR_STEP   = 1,
  parameter int unsigned BRAKE_STEP = 2,
  parameter int unsigned ADJ_STEP   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         throttle,
  input  logic         brake,
  input  logic         set,
  input  logic         resume,
  input  logic         cancel,
  input  logic         accel,
  input  logic         coast,
  output logic [W-1:0] speed,
  output logic [W-1:0] cruisespeed,
  output logic [1:0]   state,
  output logic         cruisecontrol
);

  typedef enum logic [1:0] {
    ST_OFF       = 2'b00,
    ST_ACTIVE    = 2'b01,
    ST_SUSPENDED = 2'b10,
    ST_UNUSED    = 2'b11
  } state_t;

  // Limits and steps widened to W+1 bits so sums/differences never wrap.
  localparam logic [W:0]   MAX_X   = (W+1)'(MAX_SPEED);
  localparam logic [W:0]   MIN_X   = (W+1)'(MIN_SET);
  localparam logic [W:0]   THR_X   = (W+1)'(THR_STEP);
  localparam logic [W:0]   BRK_X   = (W+1)'(BRAKE_STEP);
  localparam logic [W:0]   ADJ_X   = (W+1)'(ADJ_STEP);
  localparam logic [W:0]   ONE_X   = (W+1)'(1);
  localparam logic [W:0]   COAST_X = MIN_X + ADJ_X;
  localparam logic [W-1:0] MAX_W   = W'(MAX_SPEED);
  localparam logic [W-1:0] MIN_W   = W'(MIN_SET);

  state_t         state_reg, state_next;
  logic [W-1:0]   speed_reg, speed_next;
  logic [W-1:0]   cs_reg, cs_next;
  logic           cc_reg;

  logic [W:0]     speed_x, cs_x;
  logic           engage_ok;

  assign speed_x   = {1'b0, speed_reg};
  assign cs_x      = {1'b0, cs_reg};
  assign engage_ok = (speed_x >= MIN_X);

  // Mode and set-point decision: one prioritised chain, then accel/coast
  // only when nothing above it took effect and the pre-edge mode is ACTIVE.
  always_comb begin
    state_next = state_reg;
    cs_next    = cs_reg;
    if (!enable) begin
      state_next = ST_OFF;
      cs_next    = '0;
    end else if (brake || cancel) begin
      if (state_reg == ST_ACTIVE) state_next = ST_SUSPENDED;
    end else if (set && engage_ok) begin
      state_next = ST_ACTIVE;
      cs_next    = (speed_x > MAX_X) ? MAX_W : speed_reg;
    end else if (resume && (state_reg == ST_SUSPENDED) && engage_ok) begin
      state_next = ST_ACTIVE;
    end else if (state_reg == ST_ACTIVE) begin
      if (accel && !coast)
        cs_next = ((cs_x + ADJ_X) > MAX_X) ? MAX_W : W'(cs_x + ADJ_X);
      else if (coast && !accel)
        cs_next = (cs_x >= COAST_X) ? W'(cs_x - ADJ_X) : MIN_W;
    end
    // The unused encoding falls back to OFF unless a set re-engaged it.
    if (state_next == ST_UNUSED) state_next = ST_OFF;
  end

  // Speed model: brake beats throttle; ACTIVE without throttle closes the
  // gap to the set-point by at most THR_STEP; otherwise coast down by one.
  always_comb begin
    speed_next = speed_reg;
    if (brake) begin
      speed_next = (speed_x >= BRK_X) ? W'(speed_x - BRK_X) : '0;
    end else if (throttle) begin
      speed_next = ((speed_x + THR_X) > MAX_X) ? MAX_W : W'(speed_x + THR_X);
    end else if (state_reg == ST_ACTIVE) begin
      if (cs_x > speed_x)
        speed_next = ((cs_x - speed_x) > THR_X) ? W'(speed_x + THR_X) : cs_reg;
      else if (speed_x > cs_x)
        speed_next = ((speed_x - cs_x) > THR_X) ? W'(speed_x - THR_X) : cs_reg;
    end else begin
      speed_next = (speed_x >= ONE_X) ? W'(speed_x - ONE_X) : '0;
    end
  end

  // State register and registered outputs; cruisecontrol follows the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_OFF;
      speed_reg <= '0;
      cs_reg    <= '0;
      cc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      speed_reg <= speed_next;
      cs_reg    <= cs_next;
      cc_reg    <= (state_next == ST_ACTIVE);
    end
  end

  assign speed         = speed_reg;
  assign cruisespeed   = cs_reg;
  assign state         = state_reg;
  assign cruisecontrol = cc_reg;

endmodule

// File: tb/tb_cruise_ctrl_fsm.sv
// Testbench for cruise_ctrl_fsm: directed scenarios plus random pedal/button
// traffic, checked through a scoreboard fed by a rule-level reference model.
module tb_cruise_ctrl_fsm;
  localparam int W         = 8;
  localparam int MIN_SET   = 45;
  localparam int MAX_SPEED = 255;
  localparam int THR       = 1;
  localparam int BRK       = 2;
  localparam int ADJ       = 1;
  localparam int M_OFF     = 0;
  localparam int M_ACT     = 1;
  localparam int M_SUSP    = 2;

  logic clk = 1'b0;
  logic reset;
  logic enable, throttle, brake, set, resume, cancel, accel, coast;
  logic [W-1:0] speed, cruisespeed;
  logic [1:0]   state;
  logic         cruisecontrol;

  cruise_ctrl_fsm #(
    .W(W), .MIN_SET(MIN_SET), .MAX_SPEED(MAX_SPEED),
    .THR_STEP(THR), .BRAKE_STEP(BRK), .ADJ_STEP(ADJ)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .throttle(throttle),
    .brake(brake), .set(set), .resume(resume), .cancel(cancel),
    .accel(accel), .coast(coast), .speed(speed), .cruisespeed(cruisespeed),
    .state(state), .cruisecontrol(cruisecontrol)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sp;
    int cs;
    int st;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int txn    = 0;
  int m_sp, m_cs, m_st;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the written rules to the pre-edge model state.
  function automatic void model_step();
    int  ns, nc, nst;
    bit  fired;
    ns = m_sp; nc = m_cs; nst = m_st; fired = 1'b1;
    if (!enable) begin
      nst = M_OFF; nc = 0;
    end else if (brake || cancel) begin
      if (m_st == M_ACT) nst = M_SUSP;
    end else if (set && m_sp >= MIN_SET) begin
      nst = M_ACT; nc = imin(m_sp, MAX_SPEED);
    end else if (resume && m_st == M_SUSP && m_sp >= MIN_SET) begin
      nst = M_ACT;
    end else begin
      fired = 1'b0;
    end
    if (!fired && m_st == M_ACT) begin
      if (accel && !coast)      nc = imin(m_cs + ADJ, MAX_SPEED);
      else if (coast && !accel) nc = imax(m_cs - ADJ, MIN_SET);
    end
    if (brake)              ns = imax(m_sp - BRK, 0);
    else if (throttle)      ns = imin(m_sp + THR, MAX_SPEED);
    else if (m_st == M_ACT) begin
      if (m_sp < m_cs) ns = m_sp + imin(m_cs - m_sp, THR);
      else             ns = m_sp - imin(m_sp - m_cs, THR);
    end else                ns = imax(m_sp - 1, 0);
    m_sp = ns; m_cs = nc; m_st = nst;
  endfunction

  // Advance n clock edges, predicting each edge's outputs into the scoreboard.
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      sbq.push_back('{m_sp, m_cs, m_st});
      #1;
    end
  endtask

  task automatic apply(input bit en, input bit thr, input bit brk, input bit st,
                       input bit rs, input bit cn, input bit ac, input bit cst,
                       input int n);
    enable = en; throttle = thr; brake = brk; set = st;
    resume = rs; cancel = cn; accel = ac; coast = cst;
    cycle(n);
  endtask

  // Asynchronous reset between clock edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    enable = 1'b1; throttle = 1'b0; brake = 1'b0; set = 1'b0;
    resume = 1'b0; cancel = 1'b0; accel = 1'b0; coast = 1'b0;
    reset = 1'b1;
    #1;
    chk({tag, "_speed"}, int'(speed), 0);
    chk({tag, "_cs"}, int'(cruisespeed), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_cc"}, int'(cruisecontrol), 0);
    m_sp = 0; m_cs = 0; m_st = M_OFF;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: outputs are presented every cycle; compare each against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        txn++;
        $display("txn %0d sp=%0d cs=%0d st=%0d cc=%0d | exp sp=%0d cs=%0d st=%0d",
                 txn, speed, cruisespeed, state, cruisecontrol, e.sp, e.cs, e.st);
        chk("sb_speed", int'(speed), e.sp);
        chk("sb_cruisespeed", int'(cruisespeed), e.cs);
        chk("sb_state", int'(state), e.st);
        chk("sb_cruisecontrol", int'(cruisecontrol), (e.st == M_ACT) ? 1 : 0);
      end
    end
  end

  initial begin
    int thr_pct;
    enable = 1'b1; throttle = 1'b0; brake = 1'b0; set = 1'b0;
    resume = 1'b0; cancel = 1'b0; accel = 1'b0; coast = 1'b0;
    m_sp = 0; m_cs = 0; m_st = M_OFF;
    reset = 1'b1;
    #1;
    chk("por_speed", int'(speed), 0);
    chk("por_state", int'(state), 0);
    chk("por_cc", int'(cruisecontrol), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Engage at 50 and hold.
    apply(1,1,0,0,0,0,0,0, 50);
    chk("t1_speed50", int'(speed), 50);
    apply(1,0,0,1,0,0,0,0, 1);
    chk("t1_state", int'(state), 1);
    chk("t1_cs", int'(cruisespeed), 50);
    chk("t1_cc", int'(cruisecontrol), 1);
    apply(1,0,0,0,0,0,0,0, 10);
    chk("t1_hold", int'(speed), 50);

    // Set below and exactly at MIN_SET.
    do_reset("rst2");
    apply(1,1,0,0,0,0,0,0, 40);
    apply(1,0,0,1,0,0,0,0, 1);
    chk("t2_low_state", int'(state), 0);
    chk("t2_low_cs", int'(cruisespeed), 0);
    apply(1,1,0,0,0,0,0,0, 6);
    chk("t2_speed45", int'(speed), 45);
    apply(1,0,0,1,0,0,0,0, 1);
    chk("t2_state", int'(state), 1);
    chk("t2_cs", int'(cruisespeed), 45);

    // Brake suspends, resume re-engages and ramps back.
    do_reset("rst3");
    apply(1,1,0,0,0,0,0,0, 60);
    apply(1,1,0,1,0,0,0,0, 1);
    apply(1,0,0,0,0,0,0,0, 1);
    chk("t3_speed60", int'(speed), 60);
    apply(1,0,1,0,0,0,0,0, 3);
    chk("t3_brake_speed", int'(speed), 54);
    chk("t3_brake_state", int'(state), 2);
    chk("t3_brake_cc", int'(cruisecontrol), 0);
    apply(1,0,0,0,1,0,0,0, 1);
    chk("t3_resume_state", int'(state), 1);
    apply(1,0,0,0,0,0,0,0, 8);
    chk("t3_ramp", int'(speed), 60);

    // Coast saturates at MIN_SET; accel+coast is a no-op.
    do_reset("rst4");
    apply(1,1,0,0,0,0,0,0, 46);
    apply(1,1,0,1,0,0,0,0, 1);
    chk("t4_cs46", int'(cruisespeed), 46);
    apply(1,0,0,0,0,0,0,1, 5);
    chk("t4_coast_sat", int'(cruisespeed), 45);
    apply(1,0,0,0,0,0,1,1, 3);
    chk("t4_both", int'(cruisespeed), 45);
    apply(1,0,0,0,0,0,1,0, 2);
    chk("t4_accel", int'(cruisespeed), 47);

    // Upper and lower speed saturation.
    do_reset("rst5");
    apply(1,1,0,0,0,0,0,0, 260);
    chk("t5_max", int'(speed), 255);
    apply(1,0,1,0,0,0,0,0, 127);
    chk("t5_one", int'(speed), 1);
    apply(1,0,1,0,0,0,0,0, 1);
    chk("t5_zero", int'(speed), 0);

    // Enable drop clears memory; resume from OFF is ignored; reset mid-ramp.
    do_reset("rst6");
    apply(1,1,0,0,0,0,0,0, 50);
    apply(1,1,0,1,0,0,0,0, 1);
    apply(0,0,0,0,0,0,0,0, 1);
    chk("t6_off_state", int'(state), 0);
    chk("t6_off_cs", int'(cruisespeed), 0);
    apply(1,0,0,0,1,0,0,0, 1);
    chk("t6_resume_off", int'(state), 0);
    apply(1,0,0,1,0,0,0,0, 1);
    apply(1,0,0,0,0,0,1,0, 5);
    do_reset("rst_midramp");

    // Random traffic with varied throttle bias per block.
    for (int b = 0; b < 4; b++) begin
      thr_pct = (b == 0) ? 70 : (b == 1) ? 60 : (b == 2) ? 55 : 92;
      for (int i = 0; i < 500; i++) begin
        apply(($urandom % 40) != 0,
              $urandom_range(0, 99) < thr_pct,
              ($urandom % 8) == 0,
              ($urandom % 12) == 0,
              ($urandom % 8) == 0,
              ($urandom % 16) == 0,
              ($urandom % 4) == 0,
              ($urandom % 4) == 0,
              1);
      end
      do_reset("rst_rand");
    end

    // Let the monitor drain, bounded.
    for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
    #1;
    chk("drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
